// File: rtl/ex_pipe_skid.sv
// ex_pipe_skid: elastic ID/EX pipeline stage with a two-entry skid buffer.
// Every output is taken directly from a register. The head (main) register
// is zeroed whenever the stage empties, so an idle stage presents an
// all-zero no-op bubble downstream.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no entry held; out_valid=0, outputs are zero
// BUSY  | one entry held in main; in_ready=1
// FULL  | main and skid both held; in_ready=0 until execute consumes
module ex_pipe_skid #(
    parameter int DATA_W  = 32,
    parameter int NFIELDS = 4,
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NFIELDS*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NFIELDS*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [1:0]                occupancy,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic in_ready_q;
    logic out_valid_q;
    logic in_fire;
    logic out_fire;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic clear_main;

    logic [NFIELDS*DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0]         main_ctrl, skid_ctrl;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // State register; reset wins over flush and handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and register load selects. Flush overrides everything
    // so an entry accepted in the flush cycle is dropped.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt  = EMPTY;
                    clear_main = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt      = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt  = EMPTY;
                clear_main = 1'b1;
            end
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            clear_main     = 1'b1;
        end
    end

    // Head register: zeroed when the stage empties so the bubble is a no-op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_data <= '0;
            main_ctrl <= '0;
        end else if (clear_main) begin
            main_data <= '0;
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    // Skid register: captures the one entry absorbed after execute stalls.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    // Handshake flags registered from the next state so neither ready nor
    // valid has a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
        end
    end

    // Saturating stall counter; flush does not touch it, only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = state;

endmodule
